// File: rtl/alu_sequencer.sv
// Multi-cycle controller for a combinational 64-bit-result ALU: latches a request, holds the
// ALU inputs for a per-op settle time, then captures the result and issues HI/LO write strobes.
module alu_sequencer #(
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  op_select,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_lo,
    output logic [31:0] z_hi,
    output logic        lo_we,
    output logic        hi_we,
    output logic        div_by_zero,
    output logic        illegal_op
);

    localparam int MAX_AM  = (ALU_CYCLES > MUL_CYCLES) ? ALU_CYCLES : MUL_CYCLES;
    localparam int MAX_CYC = (MAX_AM > DIV_CYCLES) ? MAX_AM : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [31:0] z_lo_q, z_lo_d, z_hi_q, z_hi_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        lo_we_q, lo_we_d, hi_we_q, hi_we_d;
    logic        dbz_q, dbz_d, ill_q, ill_d;

    function automatic logic is_legal(input logic [4:0] op);
        return (op >= 5'b00011 && op <= 5'b01011) || (op >= 5'b01111 && op <= 5'b10010);
    endfunction

    // Illegal ops and divide-by-zero skip the settle wait and finish after a single EXEC cycle.
    function automatic logic [CNT_W-1:0] settle_cnt(input logic [4:0] op, input logic [31:0] b);
        if (!is_legal(op) || (op == OP_DIV && b == 32'd0)) return '0;
        if (op == OP_MUL) return CNT_W'(MUL_CYCLES - 1);
        if (op == OP_DIV) return CNT_W'(DIV_CYCLES - 1);
        return CNT_W'(ALU_CYCLES - 1);
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch behind.
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        z_lo_d   = z_lo_q;
        z_hi_d   = z_hi_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        lo_we_d  = 1'b0;
        hi_we_d  = 1'b0;
        dbz_d    = 1'b0;
        ill_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    alu_op_d = op_select;
                    alu_a_d  = a_in;
                    alu_b_d  = b_in;
                    cnt_d    = settle_cnt(op_select, b_in);
                    busy_d   = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!is_legal(alu_op_q)) begin
                        ill_d = 1'b1;
                    end else if (alu_op_q == OP_DIV && alu_b_q == 32'd0) begin
                        dbz_d = 1'b1;
                    end else begin
                        z_hi_d  = alu_result[63:32];
                        z_lo_d  = alu_result[31:0];
                        lo_we_d = 1'b1;
                        hi_we_d = (alu_op_q == OP_MUL) || (alu_op_q == OP_DIV);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            z_lo_q   <= '0;
            z_hi_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lo_we_q  <= 1'b0;
            hi_we_q  <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            z_lo_q   <= z_lo_d;
            z_hi_q   <= z_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lo_we_q  <= lo_we_d;
            hi_we_q  <= hi_we_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign z_lo        = z_lo_q;
    assign z_hi        = z_hi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign lo_we       = lo_we_q;
    assign hi_we       = hi_we_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small ALU model and a queue of expected completions.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  op_select;
    logic [31:0] a_in, b_in;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [63:0] alu_result;
    logic        busy, done, lo_we, hi_we, div_by_zero, illegal_op;
    logic [31:0] z_lo, z_hi;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        lo_we;
        logic        hi_we;
        logic        dbz;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_select(op_select),
        .a_in(a_in), .b_in(b_in), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy), .done(done), .z_lo(z_lo), .z_hi(z_hi),
        .lo_we(lo_we), .hi_we(hi_we), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: only the ops the bench exercises need to produce a result.
    always_comb begin
        alu_result = 64'd0;
        case (alu_op)
            5'b00011: alu_result = {32'd0, alu_a + alu_b};
            5'b00100: alu_result = {32'd0, alu_a - alu_b};
            5'b01111: alu_result = {32'd0, alu_a} * {32'd0, alu_b};
            5'b10000: alu_result = (alu_b != 0) ? {alu_a % alu_b, alu_a / alu_b} : 64'd0;
            default:  alu_result = 64'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] lo, hi, input logic lwe, hwe, dbz, ill, input int lat);
        exp_t e;
        e.lo = lo; e.hi = hi; e.lo_we = lwe; e.hi_we = hwe; e.dbz = dbz; e.ill = ill; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic compare_done(input int cyc);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_nonempty", 1'b0, 1'b1);
            return;
        end
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.lat));
        check("z_lo", z_lo, e.lo);
        check("z_hi", z_hi, e.hi);
        check("lo_we", lo_we, e.lo_we);
        check("hi_we", hi_we, e.hi_we);
        check("div_by_zero", div_by_zero, e.dbz);
        check("illegal_op", illegal_op, e.ill);
    endtask

    // Called just after a negedge; returns just after a negedge with the DUT back in IDLE.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, b, input bit repulse);
        int  cyc = 0;
        bit  got = 0;
        op_select = op; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_select = 5'b00011; a_in = ~a; b_in = 32'hdead_beef;
        check("alu_op_latched", alu_op, op);
        check("alu_a_latched", alu_a, a);
        check("alu_b_latched", alu_b, b);
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            check("busy_active", busy, 1'b1);
            if (done) begin
                got = 1;
            end else begin
                check("alu_a_stable", alu_a, a);
                check("alu_b_stable", alu_b, b);
                check("strobes_idle", {lo_we, hi_we, div_by_zero, illegal_op}, 4'b0);
                if (repulse && cyc == 2) start = 1'b1;
                if (repulse && cyc == 3) start = 1'b0;
            end
        end
        check("done_seen", got, 1'b1);
        if (got) compare_done(cyc);
        @(negedge clk);
        check("done_pulse_one_cycle", done, 1'b0);
        check("busy_after", busy, 1'b0);
        check("outs_after", {lo_we, hi_we, div_by_zero, illegal_op}, 4'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ndone;
        bit  any_done;
        rst_n = 1'b0; start = 1'b0; op_select = 5'b11111; a_in = 32'hffff_ffff; b_in = 32'hffff_ffff;
        repeat (2) @(negedge clk);
        check("rst_outputs", {alu_op, alu_a, alu_b, z_lo, z_hi}, '0);
        check("rst_ctrl", {busy, done, lo_we, hi_we, div_by_zero, illegal_op}, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);

        push_exp(32'd12, 32'd0, 1, 0, 0, 0, 2);
        run_op(5'b00011, 32'd5, 32'd7, 0);

        push_exp(32'd0, 32'd1, 1, 1, 0, 0, 3);
        run_op(5'b01111, 32'h0001_0000, 32'h0001_0000, 0);

        // start re-pulsed mid-EXEC must be dropped: exactly one done, no follow-up op
        push_exp(32'd3, 32'd2, 1, 1, 0, 0, 5);
        run_op(5'b10000, 32'd17, 32'd5, 1);
        repeat (4) @(negedge clk);
        check("no_queued_op", {busy, done}, 2'b0);

        push_exp(32'd3, 32'd2, 0, 0, 1, 0, 2);
        run_op(5'b10000, 32'd9, 32'd0, 0);

        push_exp(32'd3, 32'd2, 0, 0, 0, 1, 2);
        run_op(5'b11111, 32'd1, 32'd2, 0);

        // start held high: second op accepted in the IDLE cycle after DONE
        push_exp(32'd30, 32'd0, 1, 0, 0, 0, 2);
        push_exp(32'd42, 32'd0, 1, 0, 0, 0, 5);
        op_select = 5'b00011; a_in = 32'd10; b_in = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        op_select = 5'b00100; a_in = 32'd50; b_in = 32'd8;
        ndone = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 3) check("b2b_idle_gap", busy, 1'b0);
            if (cyc == 4) start = 1'b0;
            if (done) begin
                ndone++;
                compare_done(cyc);
            end
        end
        check("b2b_done_count", 64'(ndone), 64'd2);

        // reset mid-EXEC: everything clears at once and no done follows
        op_select = 5'b10000; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data", {alu_op, alu_a, alu_b, z_lo, z_hi}, '0);
        check("rst_mid_ctrl", {busy, done, lo_we, hi_we, div_by_zero, illegal_op}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) any_done = 1;
        end
        check("no_done_after_rst", any_done, 1'b0);

        push_exp(32'd3, 32'd0, 1, 0, 0, 0, 2);
        run_op(5'b00011, 32'd1, 32'd2, 0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
